n64_vbus_demux: RTL and testbench

N64_VBUS_DEMUX -- requirements
Module: n64_vbus_demux

---
 rtl/n64_vbus_demux.sv | 116 +++++++++++
 tb/tb_n64_vbus_demux.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/n64_vbus_demux.sv
// Demultiplexes the N64 sync/R/G/B video bus into the previous pixel and derives
// PAL/NTSC field timing and 480i interlace detection from the sync word.
module n64_vbus_demux #(
    parameter int unsigned color_width_i = 7,
    parameter logic [9:0]  pal_line_th   = 10'd288
) (
    input  logic                         VCLK,
    input  logic                         nRST,
    input  logic                         nDSYNC,
    input  logic [color_width_i-1:0]     D_i,
    output logic [1:0]                   data_cnt,
    output logic [3*color_width_i+3:0]   vdata_pre,
    output logic                         n64_480i,
    output logic                         vmode,
    output logic                         sync_err
);

    localparam int unsigned CW = color_width_i;

    logic [1:0]    r_data_cnt;
    logic [3:0]    r_sync;
    logic [CW-1:0] r_red;
    logic [CW-1:0] r_grn;
    logic [CW-1:0] r_blu;
    logic          r_sync_err;
    logic [9:0]    r_line_cnt;
    logic [1:0]    r_frame_cnt;
    logic [1:0]    r_tog_hist;
    logic          r_prev_fid;
    logic          r_480i;
    logic          r_vmode;

    logic          w_sync_cyc;
    logic          w_frame_start;
    logic          w_line_start;
    logic [1:0]    w_tog_hist_nxt;

    // Edges are found by comparing the stored sync word against the incoming one.
    assign w_sync_cyc     = ~nDSYNC;
    assign w_frame_start  = w_sync_cyc & r_sync[3] & ~D_i[3];
    assign w_line_start   = w_sync_cyc & ~r_sync[0] & D_i[0];
    assign w_tog_hist_nxt = {r_tog_hist[0], D_i[1] ^ r_prev_fid};

    always_ff @(posedge VCLK) begin : bus_phase
        if (!nRST) begin
            r_data_cnt <= 2'b00;
            r_sync_err <= 1'b0;
        end else begin
            r_sync_err <= w_sync_cyc & (r_data_cnt != 2'b00);
            r_data_cnt <= w_sync_cyc ? 2'b01 : r_data_cnt + 2'b01;
        end
    end

    always_ff @(posedge VCLK) begin : pixel_slices
        if (!nRST) begin
            r_sync <= 4'hF;
            r_red  <= '0;
            r_grn  <= '0;
            r_blu  <= '0;
        end else if (w_sync_cyc) begin
            r_sync <= D_i[3:0];
        end else begin
            case (r_data_cnt)
                2'b01:   r_red <= D_i;
                2'b10:   r_grn <= D_i;
                2'b11:   r_blu <= D_i;
                default: ;
            endcase
        end
    end

    // A line edge coinciding with frame start counts as the first line of the new field.
    always_ff @(posedge VCLK) begin : line_counter
        if (!nRST) begin
            r_line_cnt <= 10'd0;
        end else if (w_frame_start) begin
            r_line_cnt <= {9'd0, w_line_start};
        end else if (w_line_start && (r_line_cnt != 10'h3FF)) begin
            r_line_cnt <= r_line_cnt + 10'd1;
        end
    end

    always_ff @(posedge VCLK) begin : mode_detect
        if (!nRST) begin
            r_frame_cnt <= 2'd0;
            r_tog_hist  <= 2'b00;
            r_prev_fid  <= 1'b0;
            r_480i      <= 1'b0;
            r_vmode     <= 1'b0;
        end else if (w_frame_start) begin
            r_prev_fid <= D_i[1];
            r_tog_hist <= w_tog_hist_nxt;
            if (r_frame_cnt != 2'd3) begin
                r_frame_cnt <= r_frame_cnt + 2'd1;
            end
            if (r_frame_cnt >= 2'd1) begin
                r_vmode <= (r_line_cnt > pal_line_th);
            end
            // The first toggle compares against a cleared field id, so wait for real history.
            if (r_frame_cnt >= 2'd2) begin
                if (w_tog_hist_nxt == 2'b11) begin
                    r_480i <= 1'b1;
                end else if (w_tog_hist_nxt == 2'b00) begin
                    r_480i <= 1'b0;
                end
            end
        end
    end

    assign data_cnt  = r_data_cnt;
    assign vdata_pre = {r_sync, r_red, r_grn, r_blu};
    assign n64_480i  = r_480i;
    assign vmode     = r_vmode;
    assign sync_err  = r_sync_err;

endmodule

// File: tb/tb_n64_vbus_demux.sv
// Self-checking bench for n64_vbus_demux: per-cycle scoreboard against a behavioural
// model, plus directed checks of the documented scenarios.
module tb_n64_vbus_demux;

    localparam int CW = 7;
    localparam int PW = 3 * CW + 4;

    typedef struct packed {
        logic [1:0]    cnt;
        logic [PW-1:0] pre;
        logic          err;
        logic          i480;
        logic          vm;
    } exp_t;

    logic          VCLK   = 1'b0;
    logic          nRST   = 1'b0;
    logic          nDSYNC = 1'b1;
    logic [CW-1:0] D_i    = '0;
    logic [1:0]    data_cnt;
    logic [PW-1:0] vdata_pre;
    logic          n64_480i;
    logic          vmode;
    logic          sync_err;

    int n_checks = 0;
    int n_err    = 0;

    exp_t sb_q[$];

    // Behavioural model state
    logic [1:0]    m_cnt    = 2'b00;
    logic [3:0]    m_s      = 4'hF;
    logic [CW-1:0] m_r      = '0;
    logic [CW-1:0] m_g      = '0;
    logic [CW-1:0] m_b      = '0;
    logic          m_err    = 1'b0;
    logic          m_480    = 1'b0;
    logic          m_vm     = 1'b0;
    int            m_lines  = 0;
    int            m_frames = 0;
    logic [1:0]    m_hist   = 2'b00;
    logic          m_prev   = 1'b0;

    logic [1:0]    seen_cnt;
    logic [PW-1:0] seen_pre;
    logic [PW-1:0] rst_pre;

    n64_vbus_demux #(
        .color_width_i (CW),
        .pal_line_th   (10'd288)
    ) dut (
        .VCLK      (VCLK),
        .nRST      (nRST),
        .nDSYNC    (nDSYNC),
        .D_i       (D_i),
        .data_cnt  (data_cnt),
        .vdata_pre (vdata_pre),
        .n64_480i  (n64_480i),
        .vmode     (vmode),
        .sync_err  (sync_err)
    );

    always #5 VCLK = ~VCLK;

    initial begin
        #10_000_000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        end
    endtask

    task automatic model_step(input logic rst_n, input logic nd, input logic [CW-1:0] d,
                              output exp_t e);
        logic fs;
        logic ln;
        if (!rst_n) begin
            m_cnt = 2'b00; m_s = 4'hF; m_r = '0; m_g = '0; m_b = '0;
            m_err = 1'b0; m_480 = 1'b0; m_vm = 1'b0;
            m_lines = 0; m_frames = 0; m_hist = 2'b00; m_prev = 1'b0;
        end else begin
            fs = !nd && m_s[3] && !d[3];
            ln = !nd && !m_s[0] && d[0];
            m_err = !nd && (m_cnt != 2'b00);
            if (fs) begin
                if (m_frames >= 1) m_vm = (m_lines > 288);
                m_hist = {m_hist[0], d[1] ^ m_prev};
                if (m_frames >= 2) begin
                    if (m_hist == 2'b11) m_480 = 1'b1;
                    else if (m_hist == 2'b00) m_480 = 1'b0;
                end
                m_prev = d[1];
                if (m_frames < 3) m_frames = m_frames + 1;
                m_lines = ln ? 1 : 0;
            end else if (ln && m_lines < 1023) begin
                m_lines = m_lines + 1;
            end
            if (!nd) begin
                m_s = d[3:0];
            end else begin
                case (m_cnt)
                    2'b01:   m_r = d;
                    2'b10:   m_g = d;
                    2'b11:   m_b = d;
                    default: ;
                endcase
            end
            m_cnt = !nd ? 2'b01 : m_cnt + 2'b01;
        end
        e.cnt  = m_cnt;
        e.pre  = {m_s, m_r, m_g, m_b};
        e.err  = m_err;
        e.i480 = m_480;
        e.vm   = m_vm;
    endtask

    task automatic cyc(input logic rst_n, input logic nd, input logic [CW-1:0] d);
        exp_t e;
        @(negedge VCLK);
        seen_cnt = data_cnt;
        seen_pre = vdata_pre;
        nRST   = rst_n;
        nDSYNC = nd;
        D_i    = d;
        model_step(rst_n, nd, d, e);
        sb_q.push_back(e);
        @(posedge VCLK);
        #1;
        e = sb_q.pop_front();
        check_val("cycle", {2'b00, data_cnt, vdata_pre, sync_err, n64_480i, vmode},
                  {2'b00, e.cnt, e.pre, e.err, e.i480, e.vm});
    endtask

    function automatic logic [CW-1:0] rnd();
        return CW'($urandom_range(0, (1 << CW) - 1));
    endfunction

    task automatic pix(input logic [3:0] s, input logic [CW-1:0] r, input logic [CW-1:0] g,
                       input logic [CW-1:0] b);
        cyc(1'b1, 1'b0, {3'b000, s});
        cyc(1'b1, 1'b1, r);
        cyc(1'b1, 1'b1, g);
        cyc(1'b1, 1'b1, b);
    endtask

    // Frame-start pixel, then `lines` low/high nCSYNC pixel pairs; tail_low leaves nCSYNC
    // low so the next frame start coincides with a line edge.
    task automatic field(input int lines, input logic fid, input logic tail_low);
        pix({1'b0, 1'b1, fid, 1'b1}, rnd(), rnd(), rnd());
        for (int i = 0; i < lines; i++) begin
            pix(4'b1110, rnd(), rnd(), rnd());
            pix(4'b1111, rnd(), rnd(), rnd());
        end
        if (tail_low) pix(4'b1110, rnd(), rnd(), rnd());
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b1, '0);
        cyc(1'b0, 1'b1, '0);
    endtask

    task automatic reset_checks(input string tag);
        check_val({tag, "_cnt"}, 32'(data_cnt), 32'd0);
        check_val({tag, "_pre"}, 32'(vdata_pre), 32'(rst_pre));
        check_val({tag, "_480i"}, 32'(n64_480i), 32'd0);
        check_val({tag, "_vmode"}, 32'(vmode), 32'd0);
        check_val({tag, "_err"}, 32'(sync_err), 32'd0);
    endtask

    initial begin
        rst_pre = {4'hF, {(3 * CW){1'b0}}};

        do_reset();
        reset_checks("rst");

        // Idle data cycle with phase 00 must not load a slice
        cyc(1'b1, 1'b1, 7'h55);
        check_val("idle_pre", 32'(vdata_pre), 32'(rst_pre));
        check_val("idle_cnt", 32'(data_cnt), 32'd1);

        // Aligned stream phases and previous-pixel slice
        do_reset();
        cyc(1'b1, 1'b0, 7'h0F); check_val("ph_s0", 32'(seen_cnt), 32'd0);
        cyc(1'b1, 1'b1, 7'h11); check_val("ph_r0", 32'(seen_cnt), 32'd1);
        cyc(1'b1, 1'b1, 7'h22); check_val("ph_g0", 32'(seen_cnt), 32'd2);
        cyc(1'b1, 1'b1, 7'h33); check_val("ph_b0", 32'(seen_cnt), 32'd3);
        cyc(1'b1, 1'b0, 7'h0F); check_val("ph_s1", 32'(seen_cnt), 32'd0);
        cyc(1'b1, 1'b1, 7'h44); check_val("ph_r1", 32'(seen_cnt), 32'd1);
        check_val("prev_red", 32'(seen_pre[3*CW-1:2*CW]), 32'h11);
        cyc(1'b1, 1'b1, 7'h55);
        cyc(1'b1, 1'b1, 7'h66);

        // Sync word arriving in the G phase
        cyc(1'b1, 1'b0, 7'h0F);
        cyc(1'b1, 1'b1, 7'h12);
        cyc(1'b1, 1'b0, 7'h0F);
        check_val("mis_err", 32'(sync_err), 32'd1);
        check_val("mis_cnt", 32'(data_cnt), 32'd1);
        cyc(1'b1, 1'b1, 7'h13);
        check_val("mis_err_clr", 32'(sync_err), 32'd0);
        cyc(1'b1, 1'b1, 7'h14);
        cyc(1'b1, 1'b1, 7'h15);

        // NTSC progressive
        do_reset();
        field(263, 1'b1, 1'b0);
        field(263, 1'b1, 1'b0);
        check_val("ntsc_vm_f2", 32'(vmode), 32'd0);
        check_val("ntsc_480_f2", 32'(n64_480i), 32'd0);
        field(263, 1'b1, 1'b0);
        check_val("ntsc_vm_f3", 32'(vmode), 32'd0);
        check_val("ntsc_480_f3", 32'(n64_480i), 32'd0);

        // PAL interlaced
        do_reset();
        field(313, 1'b1, 1'b0);
        check_val("pal_vm_f1", 32'(vmode), 32'd0);
        check_val("pal_480_f1", 32'(n64_480i), 32'd0);
        field(312, 1'b0, 1'b0);
        check_val("pal_vm_f2", 32'(vmode), 32'd1);
        check_val("pal_480_f2", 32'(n64_480i), 32'd0);
        field(313, 1'b1, 1'b0);
        check_val("pal_vm_f3", 32'(vmode), 32'd1);
        check_val("pal_480_f3", 32'(n64_480i), 32'd1);
        field(312, 1'b0, 1'b0);
        field(313, 1'b1, 1'b0);
        check_val("pal_480_f5", 32'(n64_480i), 32'd1);

        // Reset asserted mid-pixel inside a PAL 480i field
        cyc(1'b1, 1'b0, 7'h0E);
        cyc(1'b1, 1'b1, rnd());
        cyc(1'b0, 1'b1, rnd());
        reset_checks("midrst");
        field(313, 1'b1, 1'b0);
        check_val("rel_480_f1", 32'(n64_480i), 32'd0);
        field(312, 1'b0, 1'b0);
        check_val("rel_480_f2", 32'(n64_480i), 32'd0);
        field(313, 1'b1, 1'b0);
        check_val("rel_480_f3", 32'(n64_480i), 32'd1);

        // Coincident frame start and line edge: prior count decides vmode, new count starts at 1
        do_reset();
        field(10, 1'b1, 1'b0);
        field(288, 1'b1, 1'b1);
        field(288, 1'b1, 1'b0);
        check_val("coinc_vm_prior", 32'(vmode), 32'd0);
        field(1, 1'b1, 1'b0);
        check_val("coinc_vm_next", 32'(vmode), 32'd1);

        // Line counter saturates instead of wrapping
        do_reset();
        field(10, 1'b1, 1'b0);
        field(1030, 1'b1, 1'b0);
        field(1, 1'b1, 1'b0);
        check_val("sat_vm", 32'(vmode), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
